seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 120 ++++++++++++
 tb/tb_seg_scan.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed 7-segment scanner with dead time, PWM dimming, blink and zero blanking
module seg_scan #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 16384,
    parameter int BLANK_CYC = 64,
    parameter int BLINK_DIV = 16777216
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] digits,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   blink,
    input  logic              hex_mode,
    input  logic              lz_sup,
    input  logic [3:0]        bright,
    output logic [7:0]        a_to_g,
    output logic [NDIG-1:0]   en,
    output logic              frame_pulse
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NDIG);
    localparam int BW = $clog2(BLINK_DIV);

    localparam logic [SW-1:0] SC_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SC_BLANK = SW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [BW-1:0] BC_LAST  = BW'(BLINK_DIV - 1);

    logic [SW-1:0]   sc;
    logic [IW-1:0]   idx;
    logic [BW-1:0]   bcnt;
    logic            bphase;
    logic            wrapped;

    logic [NDIG-1:0] supp;
    logic            all_zero;
    logic [3:0]      code;
    logic            pwm_on;
    logic [7:0]      seg_next;
    logic [NDIG-1:0] en_next;

    function automatic logic [6:0] decode(input logic [3:0] c, input logic hex);
        case (c)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            4'd10:   decode = hex ? 7'b0001000 : 7'b1111111;
            4'd11:   decode = hex ? 7'b1100000 : 7'b1111111;
            4'd12:   decode = hex ? 7'b0110001 : 7'b1111111;
            4'd13:   decode = hex ? 7'b1000010 : 7'b1111111;
            4'd14:   decode = hex ? 7'b0110000 : 7'b1111111;
            default: decode = hex ? 7'b0111000 : 7'b1111111;
        endcase
    endfunction

    // Slot, scan and blink timebases; wrapped marks the first slot cycle of a new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc      <= '0;
            idx     <= '0;
            bcnt    <= '0;
            bphase  <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            wrapped <= (sc == SC_LAST) && (idx == IDX_LAST);
            if (sc == SC_LAST) begin
                sc  <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                sc <= sc + 1'b1;
            end
            if (bcnt == BC_LAST) begin
                bcnt   <= '0;
                bphase <= ~bphase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        supp     = '0;
        all_zero = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            all_zero = all_zero & (digits[4*i +: 4] == 4'd0);
            supp[i]  = all_zero & lz_sup;
        end
    end

    always_comb begin
        code     = digits[idx*4 +: 4];
        pwm_on   = (bright == 4'd15) || (sc[3:0] < bright);
        seg_next = {~dp[idx], supp[idx] ? 7'b1111111 : decode(code, hex_mode)};
        en_next  = '1;
        if ((sc >= SC_BLANK) && !(bphase && blink[idx]) && pwm_on)
            en_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_to_g      <= 8'hFF;
            en          <= '1;
            frame_pulse <= 1'b0;
        end else begin
            a_to_g      <= seg_next;
            en          <= en_next;
            frame_pulse <= wrapped;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - seg_scan bench against a cycle-count arithmetic reference
module tb_seg_scan;

    localparam int NDIG = 4;
    localparam int SDIV = 32;
    localparam int BLNK = 2;
    localparam int BDIV = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic        hex_mode = 1'b0;
    logic        lz_sup = 1'b0;
    logic [3:0]  bright = 4'd15;
    logic [7:0]  a_to_g;
    logic [3:0]  en;
    logic        frame_pulse;

    int t = 0;
    int checks = 0;
    int errors = 0;

    logic [6:0] dec_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [6:0] hex_tab [6]  = '{7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
                                 7'b0111000};

    seg_scan #(.NDIG(NDIG), .SCAN_DIV(SDIV), .BLANK_CYC(BLNK), .BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blink(blink),
        .hex_mode(hex_mode), .lz_sup(lz_sup), .bright(bright),
        .a_to_g(a_to_g), .en(en), .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    // Expected outputs for the input set sampled at cycle tc after reset release.
    task automatic model(input int tc, output logic [7:0] ea, output logic [3:0] ee,
                         output logic ef);
        int s, i, bph, code;
        logic [6:0] pat;
        s    = tc % SDIV;
        i    = (tc / SDIV) % NDIG;
        bph  = (tc / BDIV) % 2;
        code = (digits >> (4 * i)) & 15;
        if (code < 10)     pat = dec_tab[code];
        else if (hex_mode) pat = hex_tab[code - 10];
        else               pat = 7'h7F;
        if (lz_sup && i > 0 && (digits >> (4 * i)) == 0) pat = 7'h7F;
        ea = {~dp[i], pat};
        if (s >= BLNK && !(bph == 1 && blink[i]) && (bright == 15 || (s % 16) < bright))
            ee = ~(4'b0001 << i);
        else
            ee = 4'hF;
        ef = (tc > 0) && (tc % (SDIV * NDIG) == 0);
    endtask

    task automatic step();
        logic [7:0] ea;
        logic [3:0] ee;
        logic       ef;
        if (!rst_n) begin
            ea = 8'hFF; ee = 4'hF; ef = 1'b0;
        end else begin
            model(t, ea, ee, ef);
        end
        @(posedge clk);
        #1;
        checks++;
        assert (a_to_g === ea) else begin
            errors++;
            $error("FAIL a_to_g t=%0d observed=%h expected=%h", t, a_to_g, ea);
        end
        checks++;
        assert (en === ee) else begin
            errors++;
            $error("FAIL en t=%0d observed=%b expected=%b", t, en, ee);
        end
        checks++;
        assert (frame_pulse === ef) else begin
            errors++;
            $error("FAIL frame_pulse t=%0d observed=%b expected=%b", t, frame_pulse, ef);
        end
        t = rst_n ? t + 1 : 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [15:0] mask;
        run(2);
        rst_n = 1'b1;

        digits = 16'h4321;
        run(140);

        digits = 16'h00A5; lz_sup = 1'b1; hex_mode = 1'b0;
        run(128);
        hex_mode = 1'b1;
        run(128);

        digits = 16'h4321; lz_sup = 1'b0; hex_mode = 1'b0; blink = 4'b0100;
        run(600);
        blink = 4'b0000;

        bright = 4'd4;
        run(128);
        bright = 4'd0;
        run(64);
        bright = 4'd15;

        digits = 16'h0000; dp = 4'b1000; lz_sup = 1'b1;
        run(128);

        digits = 16'h4321; dp = 4'b0000; lz_sup = 1'b0;
        while (!(((t / SDIV) % NDIG) == 2 && (t % SDIV) == 10)) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(80);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 6) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mask = 16'hFFFF;
                    1:       mask = 16'h00FF;
                    2:       mask = 16'h000F;
                    default: mask = 16'h0000;
                endcase
                digits   = 16'($urandom) & mask;
                dp       = 4'($urandom);
                blink    = 4'($urandom);
                hex_mode = 1'($urandom);
                lz_sup   = 1'($urandom);
                bright   = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
            end
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1;
        run(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
